button_conditioner: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/button_debounce_channel.sv | 101 ++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch front end: default timing for the button
// conditioner and the channel index assigned to each physical button.
package stopwatch_pkg;

    // 10 ms debounce and 2 s long-press at 50 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 100_000_000;

    localparam int unsigned BTN_START_STOP = 0;
    localparam int unsigned BTN_HOLD       = 1;
    localparam int unsigned BTN_SPARE      = 2;

endpackage

// File: rtl/button_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, integrating debounce counter,
// debounced level, and registered press / release / long-press pulses.
module button_debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic              RELEASED = ACTIVE_LOW;
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    logic sampled;
    logic differ;
    logic accept;

    assign sampled = sync2_q ^ ACTIVE_LOW;
    assign differ  = (sampled != level_q);
    assign accept  = differ && (db_q == DB_LAST);

    // Any sample matching the current level restarts the integration.
    always_comb begin
        db_d    = db_q;
        level_d = level_q;
        if (!differ) begin
            db_d = '0;
        end else if (accept) begin
            db_d    = '0;
            level_d = sampled;
        end else begin
            db_d = db_q + DB_W'(1);
        end
    end

    always_comb begin
        press_d   = accept && sampled;
        release_d = accept && !sampled;
    end

    // Long-press is suppressed on the release edge so it never coincides with btn_release.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q || release_d) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= RELEASED;
            sync2_q   <= RELEASED;
            db_q      <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-button pads into clean debounced levels and
// single-cycle press / release / long-press events, one channel per button.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic               CLK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (CLK_50),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing (debounce 4, long 20),
// active-low pads; every output is checked every cycle of each scenario.
module tb_button_conditioner;

    localparam int unsigned NB = 3;

    logic          CLK_50 = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    int n_assert = 0;
    int n_fail   = 0;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .CLK_50      (CLK_50),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 CLK_50 = ~CLK_50;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK_50);
        #1;
    endtask

    task automatic expect_vec(input string tag, input logic [NB-1:0] obs,
                              input logic [NB-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [NB-1:0] lvl,
                              input logic [NB-1:0] prs, input logic [NB-1:0] rel,
                              input logic [NB-1:0] lng);
        expect_vec({tag, ".level"},   btn_level,   lvl);
        expect_vec({tag, ".press"},   btn_press,   prs);
        expect_vec({tag, ".release"}, btn_release, rel);
        expect_vec({tag, ".long"},    btn_long,    lng);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 3'b111;
        step(3);
        expect_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            expect_all("idle", 3'b000, 3'b000, 3'b000, 3'b000);
        end

        // Clean press on ch0: level and press appear on the 6th edge.
        btn_raw = 3'b110;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            expect_all("press0", (i >= 6) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000,
                       3'b000, 3'b000);
        end

        // Keep holding: long fires exactly 20 cycles after press, once.
        for (int k = 2; k <= 30; k++) begin
            step(1);
            expect_all("long0", 3'b001, 3'b000, 3'b000, (k == 20) ? 3'b001 : 3'b000);
        end
        btn_raw = 3'b111;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            expect_all("rel0", (i < 6) ? 3'b001 : 3'b000, 3'b000,
                       (i == 6) ? 3'b001 : 3'b000, 3'b000);
        end

        // ch1 bounces: 3 low / 1 high, five times; never accepted.
        for (int r = 0; r < 5; r++) begin
            btn_raw = 3'b101;
            for (int i = 0; i < 3; i++) begin
                step(1);
                expect_all("bounce1", 3'b000, 3'b000, 3'b000, 3'b000);
            end
            btn_raw = 3'b111;
            step(1);
            expect_all("bounce1", 3'b000, 3'b000, 3'b000, 3'b000);
        end
        for (int i = 0; i < 6; i++) begin
            step(1);
            expect_all("bounce1_tail", 3'b000, 3'b000, 3'b000, 3'b000);
        end
        btn_raw = 3'b101;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            expect_all("press1", (i >= 6) ? 3'b010 : 3'b000, (i == 6) ? 3'b010 : 3'b000,
                       3'b000, 3'b000);
        end
        btn_raw = 3'b111;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            expect_all("rel1", (i < 6) ? 3'b010 : 3'b000, 3'b000,
                       (i == 6) ? 3'b010 : 3'b000, 3'b000);
        end

        // ch0 and ch2 pressed together for 10 cycles: short press, no long.
        btn_raw = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            expect_all("simul", (i >= 6 && i < 16) ? 3'b101 : 3'b000,
                       (i == 6) ? 3'b101 : 3'b000, (i == 16) ? 3'b101 : 3'b000, 3'b000);
            if (i == 10) btn_raw = 3'b111;
        end

        // Reset 8 cycles into a long press, button kept held throughout.
        btn_raw = 3'b110;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            expect_all("pre_rst", (i >= 6) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000,
                       3'b000, 3'b000);
        end
        reset = 1'b1;
        step(1);
        expect_all("rst_mid", 3'b000, 3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            expect_all("post_rst", (i >= 6) ? 3'b001 : 3'b000, (i == 6) ? 3'b001 : 3'b000,
                       3'b000, (i == 26) ? 3'b001 : 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
